// File: rtl/alu32_seq_ctrl.sv
// Two-pass 32-bit ALU sequencer around a shared combinational 16-bit slice.
// The LO pass runs bits 15:0, the HI pass runs bits 31:16 with the carry chained between them.
module alu32_seq_ctrl #(
    parameter int HALF_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    // Handshake on both ports: a transfer happens on a rising edge where valid & ready are both 1;
    // valid, once raised, holds with its payload stable until that transfer.
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*HALF_W-1:0]   in_a,
    input  logic [2*HALF_W-1:0]   in_b,
    input  logic [2:0]            in_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*HALF_W-1:0]   out_result,
    output logic                  out_zero,
    output logic                  out_cout,
    output logic                  out_ovf,
    output logic                  out_err,
    output logic [HALF_W-1:0]     alu_a,
    output logic [HALF_W-1:0]     alu_b,
    output logic                  alu_cin,
    output logic                  alu_less,
    output logic [2:0]            alu_op,
    input  logic [HALF_W-1:0]     alu_result,
    input  logic                  alu_cout,
    input  logic                  alu_set,
    input  logic                  alu_zero,
    input  logic                  alu_overflow,
    output logic [1:0]            dbg_state
);

    localparam int W = 2 * HALF_W;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic [2:0]          op_q;
    logic                carry_q;
    logic [HALF_W-1:0]   lo_res_q;
    logic                lo_zero_q;
    logic                accept;
    logic                in_legal;
    logic                slt_bit;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: op_legal = 1'b1;
            default:                               op_legal = 1'b0;
        endcase
    endfunction

    assign in_legal  = op_legal(in_op);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);
    assign dbg_state = state;
    // Signed less-than from the full 32-bit subtraction done across both passes
    assign slt_bit   = alu_set ^ alu_overflow;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_cin   = 1'b0;
        alu_less  = 1'b0;
        alu_op    = 3'b000;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = in_legal ? LO : DONE;
            end
            LO: begin
                alu_a     = a_q[HALF_W-1:0];
                alu_b     = b_q[HALF_W-1:0];
                alu_op    = op_q;
                alu_cin   = op_q[2];
                state_nxt = HI;
            end
            HI: begin
                alu_a     = a_q[W-1:HALF_W];
                alu_b     = b_q[W-1:HALF_W];
                alu_op    = op_q;
                // Only the arithmetic ops (op[1]=1) chain the carry
                alu_cin   = op_q[1] & carry_q;
                state_nxt = DONE;
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) state_nxt = in_legal ? LO : DONE;
                    else          state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 3'b000;
            carry_q    <= 1'b0;
            lo_res_q   <= '0;
            lo_zero_q  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_cout   <= 1'b0;
            out_ovf    <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q  <= in_a;
                b_q  <= in_b;
                op_q <= in_op;
                if (!in_legal) begin
                    out_result <= '0;
                    out_zero   <= 1'b1;
                    out_cout   <= 1'b0;
                    out_ovf    <= 1'b0;
                    out_err    <= 1'b1;
                end
            end
            if (state == LO) begin
                lo_res_q  <= alu_result;
                carry_q   <= alu_cout;
                lo_zero_q <= alu_zero;
            end
            if (state == HI) begin
                out_err <= 1'b0;
                if (op_q == OP_SLT) begin
                    out_result <= {{(W-1){1'b0}}, slt_bit};
                    out_zero   <= ~slt_bit;
                    out_cout   <= 1'b0;
                    out_ovf    <= 1'b0;
                end else begin
                    out_result <= {alu_result, lo_res_q};
                    out_zero   <= alu_zero & lo_zero_q;
                    out_cout   <= alu_cout;
                    out_ovf    <= ((op_q == OP_ADD) || (op_q == OP_SUB)) & alu_overflow;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu32_seq_ctrl.sv
// Self-checking bench for alu32_seq_ctrl: models the 16-bit slice, checks 32-bit results
// against a whole-word arithmetic reference, plus latency, back-pressure and reset cases.
module tb_alu32_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_cout;
    logic        out_ovf;
    logic        out_err;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_cin;
    logic        alu_less;
    logic [2:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_cout;
    logic        alu_set;
    logic        alu_zero;
    logic        alu_overflow;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [35:0] exp_q[$];

    alu32_seq_ctrl #(.HALF_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_cout(out_cout), .out_ovf(out_ovf), .out_err(out_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_less(alu_less), .alu_op(alu_op),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_set(alu_set),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit combinational slice model
    logic [15:0] slice_bb;
    logic [16:0] slice_sum;
    always_comb begin
        slice_bb     = alu_op[2] ? ~alu_b : alu_b;
        slice_sum    = {1'b0, alu_a} + {1'b0, slice_bb} + {16'b0, alu_cin};
        alu_result   = 16'h0;
        alu_cout     = 1'b0;
        alu_set      = 1'b0;
        alu_overflow = 1'b0;
        case (alu_op)
            3'b000: alu_result = alu_a & alu_b;
            3'b001: alu_result = alu_a | alu_b;
            3'b010, 3'b110, 3'b111: begin
                alu_result   = slice_sum[15:0];
                alu_cout     = slice_sum[16];
                alu_set      = slice_sum[15];
                alu_overflow = (alu_a[15] == slice_bb[15]) && (slice_sum[15] != alu_a[15]);
            end
            default: alu_result = 16'h0;
        endcase
        alu_zero = (alu_result == 16'h0);
    end

    // reference model: {err, ovf, cout, zero, result}
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [32:0] s;
        logic [31:0] res;
        logic        cout, ovf, err;
        res = 32'h0; cout = 1'b0; ovf = 1'b0; err = 1'b0;
        case (op)
            3'b000: res = a & b;
            3'b001: res = a | b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                res = s[31:0]; cout = s[32];
                ovf = (a[31] == b[31]) && (res[31] != a[31]);
            end
            3'b110: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                res = s[31:0]; cout = s[32];
                ovf = (a[31] != b[31]) && (res[31] != a[31]);
            end
            3'b111: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: err = 1'b1;
        endcase
        model = {err, ovf, cout, (res == 32'h0), res};
    endfunction

    function automatic logic legal(input logic [2:0] op);
        legal = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) || (op == 3'b110) || (op == 3'b111);
    endfunction

    // carry out of the low 16 bits of the full-word operation
    function automatic logic lo_carry(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [16:0] s;
        if (op[1] == 1'b0) lo_carry = 1'b0;
        else begin
            s = {1'b0, a[15:0]} + {1'b0, (op[2] ? ~b[15:0] : b[15:0])} + {16'b0, op[2]};
            lo_carry = s[16];
        end
    endfunction

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] outs();
        outs = {out_err, out_ovf, out_cout, out_zero, out_result};
    endfunction

    // driver: called at a negedge with the DUT ready; request accepted at next posedge
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        #1;
        check("in_ready_at_issue", in_ready, 1'b1);
        exp_q.push_back(model(a, b, op));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_a = $urandom; in_b = $urandom; in_op = 3'($urandom_range(0, 7));
    endtask

    // follows one accepted op to its response and stalls for a number of cycles
    task automatic collect(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input int stall);
        logic [35:0] exp;
        if (legal(op)) begin
            @(negedge clk);
            check("lo_valid", out_valid, 1'b0);
            check("lo_in_ready", in_ready, 1'b0);
            check("lo_alu_a", alu_a, a[15:0]);
            check("lo_alu_b", alu_b, b[15:0]);
            check("lo_alu_op", alu_op, op);
            check("lo_alu_cin", alu_cin, op[2]);
            check("lo_alu_less", alu_less, 1'b0);
            @(negedge clk);
            check("hi_valid", out_valid, 1'b0);
            check("hi_alu_a", alu_a, a[31:16]);
            check("hi_alu_b", alu_b, b[31:16]);
            check("hi_alu_cin", alu_cin, lo_carry(a, b, op));
        end
        @(negedge clk);
        check("resp_valid", out_valid, 1'b1);
        exp = exp_q.pop_front();
        check("resp_value", outs(), exp);
        check("done_alu_idle", {alu_a, alu_b, alu_op, alu_cin}, 36'h0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1'b1);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_stable", outs(), exp);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        #1;
        check("done_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("idle_valid", out_valid, 1'b0);
        check("idle_state", dbg_state, 2'd0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input int stall);
        issue(a, b, op);
        collect(a, b, op, stall);
        consume();
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] corners [6];
        corners = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h0000FFFF, 32'h1};
        if ($urandom_range(0, 2) == 0) rand_operand = corners[$urandom_range(0, 5)];
        else                           rand_operand = $urandom;
    endfunction

    function automatic logic [2:0] rand_op();
        logic [2:0] ops [5];
        ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
        if ($urandom_range(0, 7) == 0) rand_op = 3'($urandom_range(0, 7));
        else                           rand_op = ops[$urandom_range(0, 4)];
    endfunction

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
        #2;
        check("rst_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_outs", outs(), 36'h0);
        check("rst_state", dbg_state, 2'd0);
        check("rst_alu", {alu_a, alu_b, alu_op, alu_cin, alu_less}, 37'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'h0000FFFF, 32'h00000001, 3'b010, 0);
        run_op(32'h12345678, 32'h12345678, 3'b110, 1);
        run_op(32'h7FFFFFFF, 32'h00000001, 3'b010, 0);
        run_op(32'hFFFFFFFF, 32'h00000001, 3'b111, 0);
        run_op(32'h80000000, 32'h7FFFFFFF, 3'b111, 0);
        run_op(32'h00000005, 32'hFFFFFFFD, 3'b111, 0);
        run_op(32'hF0F0A5A5, 32'h0FF0FFFF, 3'b000, 0);
        run_op(32'hF0F0A5A5, 32'h0FF00000, 3'b001, 0);

        // back-pressure then back-to-back accept
        issue(32'hDEADBEEF, 32'h01234567, 3'b010);
        collect(32'hDEADBEEF, 32'h01234567, 3'b010, 5);
        out_ready = 1'b1;
        issue(32'h00000010, 32'h00000020, 3'b110);
        collect(32'h00000010, 32'h00000020, 3'b110, 0);
        consume();

        // illegal op, standalone and chained after a legal op
        run_op(32'h11111111, 32'h22222222, 3'b011, 0);
        issue(32'h3, 32'h4, 3'b010);
        collect(32'h3, 32'h4, 3'b010, 0);
        out_ready = 1'b1;
        issue(32'h5, 32'h6, 3'b101);
        collect(32'h5, 32'h6, 3'b101, 1);
        consume();

        // reset during the HI pass drops the op
        issue(32'h0000FFFF, 32'h0000FFFF, 3'b010);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_state_hi", dbg_state, 2'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_outs", outs(), 36'h0);
        check("mid_rst_alu", {alu_a, alu_b, alu_op, alu_cin}, 36'h0);
        check("mid_rst_state", dbg_state, 2'd0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_resp_after_rst", out_valid, 1'b0);
        end
        run_op(32'hAAAA5555, 32'h5555AAAB, 3'b010, 0);

        // randomized traffic, mixing chained and idle-separated requests
        for (int n = 0; n < 40; n++) begin
            ra = rand_operand(); rb = rand_operand(); rop = rand_op();
            issue(ra, rb, rop);
            collect(ra, rb, rop, $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) out_ready = 1'b1;
            else consume();
        end
        ra = 32'h1; rb = 32'h2; rop = 3'b110;
        issue(ra, rb, rop);
        collect(ra, rb, rop, 0);
        consume();

        check("exp_q_empty", 36'(exp_q.size()), 36'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
